// File: rtl/mdr_driver_pkg.sv
// Shared types for the mdr command-side driver: opcodes, driver FSM states,
// response status codes and default-width data buses.
package mdr_driver_pkg;

  localparam int MDR_DW = 16;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_ROOT = 2'd2,
    OP_INV  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } drv_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ERR     = 2'd1,
    ST_TIMEOUT = 2'd2
  } rsp_status_e;

  // Operand bus and double-width result bus at the default operand width.
  typedef logic [MDR_DW-1:0]   data_in_t;
  typedef logic [2*MDR_DW-1:0] data_t;

endpackage

// File: rtl/mdr_driver_timeout_counter.sv
// Watchdog counter for the RUN phase: counts enabled cycles since the last
// clear and flags the last allowed cycle (count == TIMEOUT-1).
module timeout_counter #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over enable so a fresh command always starts from zero.
  always_comb begin
    count_d = count_q;
    if (i_clear)       count_d = '0;
    else if (i_enable) count_d = count_q + CW'(1);
  end

  // Count register, zeroed on asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign o_expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_driver.sv
// Command-side initiator for mdr: accepts one (op, X, Y) command, starts mdr,
// serves each operand request once, and returns result/remainder/status.
module mdr_driver
  import mdr_driver_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [DW-1:0]   cmd_x,
  input  logic [DW-1:0]   cmd_y,
  output logic            mdr_start,
  output logic            mdr_load,
  output logic [DW-1:0]   mdr_data,
  output logic [1:0]      mdr_op,
  input  logic            mdr_load_x,
  input  logic            mdr_load_y,
  input  logic            mdr_ready,
  input  logic            mdr_error,
  input  logic [2*DW-1:0] mdr_result,
  input  logic [DW-1:0]   mdr_reminder,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_result,
  output logic [DW-1:0]   rsp_reminder,
  output logic [1:0]      rsp_status
);

  drv_state_e  state_q, state_d;
  logic [DW-1:0]   x_q, x_d, y_q, y_d;
  logic            x_sent_q, x_sent_d, y_sent_q, y_sent_d;
  logic            mdr_start_q, mdr_start_d, mdr_load_q, mdr_load_d;
  logic [DW-1:0]   mdr_data_q, mdr_data_d;
  logic [1:0]      mdr_op_q, mdr_op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2*DW-1:0] rsp_result_q, rsp_result_d;
  logic [DW-1:0]   rsp_reminder_q, rsp_reminder_d;
  rsp_status_e     rsp_status_q, rsp_status_d;
  logic            tmo_expired;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (state_q == START),
    .i_enable  (state_q == RUN),
    .o_expired (tmo_expired)
  );

  // Next-state and registered-output decode; strobes default low each cycle.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    x_sent_d       = x_sent_q;
    y_sent_d       = y_sent_q;
    mdr_start_d    = 1'b0;
    mdr_load_d     = 1'b0;
    mdr_data_d     = '0;
    mdr_op_d       = mdr_op_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_reminder_d = rsp_reminder_q;
    rsp_status_d   = rsp_status_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x_d      = cmd_x;
          y_d      = cmd_y;
          x_sent_d = 1'b0;
          y_sent_d = 1'b0;
          if (op_t'(cmd_op) == OP_INV) begin
            // Invalid opcode never reaches mdr; answer immediately.
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_result_d   = '0;
            rsp_reminder_d = '0;
            rsp_status_d   = ST_ERR;
          end else begin
            state_d     = START;
            mdr_start_d = 1'b1;
            mdr_op_d    = cmd_op;
          end
        end
      end
      START: begin
        state_d = RUN;
      end
      RUN: begin
        // Completion and timeout outrank operand service, so a request
        // arriving with them is dropped.
        if (mdr_error) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = '0;
          rsp_reminder_d = '0;
          rsp_status_d   = ST_ERR;
        end else if (mdr_ready) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = mdr_result;
          rsp_reminder_d = mdr_reminder;
          rsp_status_d   = ST_OK;
        end else if (tmo_expired) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = '0;
          rsp_reminder_d = '0;
          rsp_status_d   = ST_TIMEOUT;
        end else if (mdr_load_x && !x_sent_q) begin
          mdr_load_d = 1'b1;
          mdr_data_d = x_q;
          x_sent_d   = 1'b1;
        end else if (mdr_load_y && !y_sent_q) begin
          mdr_load_d = 1'b1;
          mdr_data_d = y_q;
          y_sent_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          mdr_op_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      x_sent_q       <= 1'b0;
      y_sent_q       <= 1'b0;
      mdr_start_q    <= 1'b0;
      mdr_load_q     <= 1'b0;
      mdr_data_q     <= '0;
      mdr_op_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_reminder_q <= '0;
      rsp_status_q   <= ST_OK;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      x_sent_q       <= x_sent_d;
      y_sent_q       <= y_sent_d;
      mdr_start_q    <= mdr_start_d;
      mdr_load_q     <= mdr_load_d;
      mdr_data_q     <= mdr_data_d;
      mdr_op_q       <= mdr_op_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_reminder_q <= rsp_reminder_d;
      rsp_status_q   <= rsp_status_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign mdr_start    = mdr_start_q;
  assign mdr_load     = mdr_load_q;
  assign mdr_data     = mdr_data_q;
  assign mdr_op       = mdr_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_reminder = rsp_reminder_q;
  assign rsp_status   = rsp_status_q;

endmodule

// File: tb/tb_mdr_driver.sv
// Directed bench for mdr_driver: the stimulus plays the mdr side by hand and
// queues expected responses; a negedge monitor pops and compares them.
module tb_mdr_driver;
  import mdr_driver_pkg::*;

  localparam int DW = 16;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [DW-1:0]   cmd_x = '0, cmd_y = '0;
  logic            mdr_start, mdr_load;
  logic [DW-1:0]   mdr_data;
  logic [1:0]      mdr_op;
  logic            mdr_load_x = 1'b0, mdr_load_y = 1'b0;
  logic            mdr_ready = 1'b0, mdr_error = 1'b0;
  logic [2*DW-1:0] mdr_result = '0;
  logic [DW-1:0]   mdr_reminder = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [2*DW-1:0] rsp_result;
  logic [DW-1:0]   rsp_reminder;
  logic [1:0]      rsp_status;

  typedef struct packed {
    logic [2*DW-1:0] res;
    logic [DW-1:0]   rem;
    logic [1:0]      st;
  } exp_t;

  exp_t sb[$];
  int   load_log[$];
  int   start_cnt = 0;
  int   n_rsp = 0;
  int   rsp_target = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mdr_driver #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .mdr_start(mdr_start), .mdr_load(mdr_load), .mdr_data(mdr_data),
    .mdr_op(mdr_op), .mdr_load_x(mdr_load_x), .mdr_load_y(mdr_load_y),
    .mdr_ready(mdr_ready), .mdr_error(mdr_error),
    .mdr_result(mdr_result), .mdr_reminder(mdr_reminder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_reminder(rsp_reminder),
    .rsp_status(rsp_status)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: log mdr strobes and score every response handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (mdr_start) start_cnt++;
      if (mdr_load) load_log.push_back(int'(mdr_data));
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {62'd0, rsp_status}, 64'h0);
          chk("unexpected_rsp_valid", 64'(rsp_valid), 64'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_reminder", 64'(rsp_reminder), 64'(e.rem));
          chk("rsp_status", 64'(rsp_status), 64'(e.st));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. in the START (or RESP for INV) cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    for (int i = 0; i < 50 && !cmd_ready; i++) step();
    chk("cmd_ready_before_send", 64'(cmd_ready), 64'h1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y;
    step();
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0;
  endtask

  task automatic expect_rsp(input logic [2*DW-1:0] r, input logic [DW-1:0] m, input logic [1:0] s);
    exp_t e;
    e.res = r; e.rem = m; e.st = s;
    sb.push_back(e);
    rsp_target++;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100 && n_rsp < rsp_target; i++) @(posedge clk);
    #1;
    if (n_rsp < rsp_target) chk("rsp_wait_timeout", 64'(n_rsp), 64'(rsp_target));
  endtask

  task automatic finish_result(input logic [2*DW-1:0] r, input logic [DW-1:0] m, input logic err);
    mdr_ready = 1'b1; mdr_error = err; mdr_result = r; mdr_reminder = m;
    step();
    mdr_ready = 1'b0; mdr_error = 1'b0; mdr_result = '0; mdr_reminder = '0;
  endtask

  initial begin
    int s0, l0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("rst_mdr_start", 64'(mdr_start), 64'h0);
    chk("rst_mdr_load", 64'(mdr_load), 64'h0);
    chk("rst_mdr_data", 64'(mdr_data), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    rst = 1'b1;
    step();

    // 1: MULT 3*5, X held for 4 cycles then Y
    s0 = start_cnt; l0 = load_log.size();
    expect_rsp(32'd15, 16'd0, ST_OK);
    send_cmd(OP_MULT, 16'd3, 16'd5);
    chk("t1_start_pulse", 64'(mdr_start), 64'h1);
    chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'h0);
    step();
    chk("t1_start_one_cycle", 64'(mdr_start), 64'h0);
    mdr_load_x = 1'b1;
    repeat (4) step();
    mdr_load_x = 1'b0; mdr_load_y = 1'b1;
    step();
    mdr_load_y = 1'b0;
    step(); step();
    finish_result(32'd15, 16'd0, 1'b0);
    wait_rsp();
    chk("t1_starts", 64'(start_cnt - s0), 64'd1);
    chk("t1_loads", 64'(load_log.size() - l0), 64'd2);
    if (load_log.size() - l0 == 2) begin
      chk("t1_load0", 64'(load_log[l0]), 64'd3);
      chk("t1_load1", 64'(load_log[l0+1]), 64'd5);
    end

    // 2: ROOT 49, only X requested
    l0 = load_log.size();
    expect_rsp(32'd7, 16'd0, ST_OK);
    send_cmd(OP_ROOT, 16'd49, 16'd99);
    step();
    chk("t2_mdr_op", 64'(mdr_op), 64'd2);
    mdr_load_x = 1'b1; step(); mdr_load_x = 1'b0;
    step(); step();
    finish_result(32'd7, 16'd0, 1'b0);
    wait_rsp();
    chk("t2_loads", 64'(load_log.size() - l0), 64'd1);
    if (load_log.size() - l0 == 1) chk("t2_load0", 64'(load_log[l0]), 64'd49);
    chk("t2_mdr_op_cleared", 64'(mdr_op), 64'd0);

    // 3a: DIV 10/0 -> mdr_error after loads
    expect_rsp(32'd0, 16'd0, ST_ERR);
    send_cmd(OP_DIV, 16'd10, 16'd0);
    step();
    chk("t3_mdr_op", 64'(mdr_op), 64'd1);
    mdr_load_x = 1'b1; step(); mdr_load_x = 1'b0;
    mdr_load_y = 1'b1; step(); mdr_load_y = 1'b0;
    finish_result(32'd0, 16'd0, 1'b1);
    wait_rsp();
    // 3b: ready and error together resolve as ERR with zeroed data
    expect_rsp(32'd0, 16'd0, ST_ERR);
    send_cmd(OP_DIV, 16'd9, 16'd2);
    step();
    mdr_load_x = 1'b1; step(); mdr_load_x = 1'b0;
    mdr_load_y = 1'b1; step(); mdr_load_y = 1'b0;
    finish_result(32'd5, 16'd3, 1'b1);
    wait_rsp();

    // 4: INV -> immediate ERR, mdr untouched
    s0 = start_cnt; l0 = load_log.size();
    expect_rsp(32'd0, 16'd0, ST_ERR);
    send_cmd(OP_INV, 16'd1, 16'd1);
    chk("t4_rsp_valid_k1", 64'(rsp_valid), 64'h1);
    chk("t4_status_k1", 64'(rsp_status), 64'(ST_ERR));
    wait_rsp();
    chk("t4_no_start", 64'(start_cnt - s0), 64'd0);
    chk("t4_no_load", 64'(load_log.size() - l0), 64'd0);

    // 5: timeout after TMO RUN cycles; both requests at once, X served first
    l0 = load_log.size();
    expect_rsp(32'd0, 16'd0, ST_TIMEOUT);
    send_cmd(OP_MULT, 16'd1, 16'd2);
    step();
    mdr_load_x = 1'b1; mdr_load_y = 1'b1;
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (i == 1) mdr_load_x = 1'b0;
      if (i == 2) mdr_load_y = 1'b0;
      if (i == TMO - 1) chk("t5_no_rsp_before", 64'(rsp_valid), 64'h0);
      if (i == TMO) chk("t5_rsp_at_tmo", 64'(rsp_valid), 64'h1);
    end
    wait_rsp();
    chk("t5_loads", 64'(load_log.size() - l0), 64'd2);
    if (load_log.size() - l0 == 2) begin
      chk("t5_load0_x", 64'(load_log[l0]), 64'd1);
      chk("t5_load1_y", 64'(load_log[l0+1]), 64'd2);
    end

    // 6a: back-pressured response held stable
    rsp_ready = 1'b0;
    expect_rsp(32'd4, 16'd0, ST_OK);
    send_cmd(OP_MULT, 16'd2, 16'd2);
    step();
    mdr_load_x = 1'b1; step(); mdr_load_x = 1'b0;
    mdr_load_y = 1'b1; step(); mdr_load_y = 1'b0;
    finish_result(32'd4, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_valid", 64'(rsp_valid), 64'h1);
      chk("t6_hold_result", 64'(rsp_result), 64'd4);
      chk("t6_hold_cmd_ready", 64'(cmd_ready), 64'h0);
      step();
    end
    rsp_ready = 1'b1;
    wait_rsp();

    // 6b: reset asserted mid-RUN
    send_cmd(OP_MULT, 16'd7, 16'd7);
    step();
    mdr_load_x = 1'b1; step(); mdr_load_x = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("t6_rst_mdr_load", 64'(mdr_load), 64'h0);
    chk("t6_rst_mdr_data", 64'(mdr_data), 64'h0);
    chk("t6_rst_mdr_op", 64'(mdr_op), 64'h0);
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t6_rst_rsp_result", 64'(rsp_result), 64'h0);
    step();
    rst = 1'b1;
    finish_result(32'd49, 16'd0, 1'b0);
    repeat (10) step();
    chk("t6_no_stale_rsp", 64'(rsp_valid), 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
